bw_ioslave_dlx: RTL and testbench

- Parametrised, synthesizable multi-channel slave delay line for the DDR DQS path; successor to the single-channel behavioural slave delay.
- Each channel's dqs_in is oversampled into a DEPTH-tap shift line clocked by clk, and one tap is selected as dqs_out.
- Tap selection comes from the master DLL code lpf_out, scaled by SHIFT.
- Code changes are applied per channel only in a glitch-free window, with a timeout fallback.
- Selection registers sit on the scan chain.

---
 rtl/bw_ioslave_dlx.sv | 172 +++++++++++++++++
 tb/tb_bw_ioslave_dlx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bw_ioslave_dlx.sv
// Multi-channel DQS slave delay line: oversampled tap line with glitch-free tap switching.
// Optional per-channel signed trim of the target tap is enabled by BW_IOSLAVE_DL_TRIM_EN.
module bw_ioslave_dlx #(
  parameter int NCH    = 4,
  parameter int CODE_W = 5,
  parameter int DEPTH  = 32,
  parameter int SEL_W  = 5,
  parameter int SHIFT  = 0,
  parameter int TMO    = 64,
  parameter int TRIM_W = 3
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [NCH-1:0]    dqs_in,
  input  logic [CODE_W-1:0] lpf_out,
  input  logic              strobe,
  input  logic              se,
  input  logic              si,
  output logic [NCH-1:0]    dqs_out,
  output logic              so,
  output logic [NCH-1:0]    upd_done,
  output logic [NCH-1:0]    upd_tmo
`ifdef BW_IOSLAVE_DL_TRIM_EN
  ,
  input  logic [NCH*TRIM_W-1:0] trim
`endif
);

  localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int CH_W  = NCH * SEL_W;

  typedef enum logic {IDLE, PEND} st_e;

  logic [DEPTH-1:0]  line_q  [NCH];
  logic [SEL_W-1:0]  sel_q   [NCH];
  logic [SEL_W-1:0]  sel_d   [NCH];
  logic [CNT_W-1:0]  tmo_q   [NCH];
  logic [CNT_W-1:0]  tmo_d   [NCH];
  st_e               state_q [NCH];
  st_e               state_d [NCH];
  logic [SEL_W-1:0]  tgt     [NCH];
  logic [NCH-1:0]    quiet;
  logic [CODE_W-1:0] code_q, code_d;
  logic [NCH-1:0]    dqs_q;
  logic [NCH-1:0]    done_q, done_d;
  logic [NCH-1:0]    tflag_q, tflag_d;
  logic              so_q, so_d;
  logic [CH_W-1:0]   chain, chain_sh;
  logic              cap;

  function automatic logic [SEL_W-1:0] sat_tap(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    else if (v > DEPTH - 1)
      return SEL_W'(DEPTH - 1);
    else
      return v[SEL_W-1:0];
  endfunction

  function automatic logic signed [31:0] trim_of(input int c);
    logic signed [TRIM_W-1:0] tr;
`ifdef BW_IOSLAVE_DL_TRIM_EN
    tr = trim[c*TRIM_W +: TRIM_W];
`else
    tr = '0;
    if (c < 0) tr = '1;
`endif
    return 32'(tr);
  endfunction

  always_comb begin
    cap      = strobe & ~se;
    code_d   = cap ? lpf_out : code_q;
    chain    = '0;
    for (int c = 0; c < NCH; c++)
      chain[c*SEL_W +: SEL_W] = sel_q[c];
    chain_sh = {chain[CH_W-2:0], si};
    so_d     = chain[CH_W-1];
    for (int c = 0; c < NCH; c++) begin
      logic signed [31:0] base;
      logic [SEL_W-1:0]   lo, hi;
      logic               cur;
      base       = signed'(32'(code_q >> SHIFT));
      tgt[c]     = sat_tap(base + trim_of(c));
      lo         = (tgt[c] < sel_q[c]) ? tgt[c] : sel_q[c];
      hi         = (tgt[c] < sel_q[c]) ? sel_q[c] : tgt[c];
      cur        = line_q[c][sel_q[c]];
      quiet[c]   = 1'b1;
      for (int i = 0; i < DEPTH; i++)
        if (i >= int'(lo) && i <= int'(hi) && line_q[c][i] != cur)
          quiet[c] = 1'b0;

      state_d[c] = state_q[c];
      sel_d[c]   = sel_q[c];
      tmo_d[c]   = tmo_q[c];
      done_d[c]  = 1'b0;
      tflag_d[c] = tflag_q[c];
      if (se) begin
        // Scan shifts the selection registers; everything else holds.
        sel_d[c] = chain_sh[c*SEL_W +: SEL_W];
      end else begin
        if (state_q[c] == PEND) begin
          if (tgt[c] == sel_q[c]) begin
            state_d[c] = IDLE;
            done_d[c]  = 1'b1;
          end else if (quiet[c]) begin
            sel_d[c]   = tgt[c];
            state_d[c] = IDLE;
            done_d[c]  = 1'b1;
          end else if (tmo_q[c] == CNT_W'(TMO - 1)) begin
            sel_d[c]   = tgt[c];
            state_d[c] = IDLE;
            done_d[c]  = 1'b1;
            tflag_d[c] = 1'b1;
          end else begin
            tmo_d[c] = tmo_q[c] + CNT_W'(1);
          end
        end
        // A capture in the same cycle as an apply re-arms with the new code.
        if (cap) begin
          state_d[c] = PEND;
          tmo_d[c]   = '0;
          tflag_d[c] = 1'b0;
        end
      end
    end
  end

  // Stage p0: tap line and registered tap read
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int c = 0; c < NCH; c++) line_q[c] <= '0;
      dqs_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        line_q[c] <= {line_q[c][DEPTH-2:0], dqs_in[c]};
        dqs_q[c]  <= line_q[c][sel_q[c]];
      end
    end
  end

  // Stage p1: update control state and scan chain
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int c = 0; c < NCH; c++) begin
        sel_q[c]   <= '0;
        tmo_q[c]   <= '0;
        state_q[c] <= IDLE;
      end
      code_q  <= '0;
      done_q  <= '0;
      tflag_q <= '0;
      so_q    <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        sel_q[c]   <= sel_d[c];
        tmo_q[c]   <= tmo_d[c];
        state_q[c] <= state_d[c];
      end
      code_q  <= code_d;
      done_q  <= done_d;
      tflag_q <= tflag_d;
      so_q    <= so_d;
    end
  end

  assign dqs_out  = dqs_q;
  assign upd_done = done_q;
  assign upd_tmo  = tflag_q;
  assign so       = so_q;

endmodule

// File: tb/tb_bw_ioslave_dlx.sv
// Directed bench for bw_ioslave_dlx: default instance plus SHIFT=2 and DEPTH=16 variants.
module tb_bw_ioslave_dlx;

  logic        clk;
  logic        rst_l;
  logic [3:0]  dqs_in;
  logic [4:0]  lpf_out;
  logic        strobe, se, si;
  logic [3:0]  dqs_out, upd_done, upd_tmo;
  logic        so;
  logic [3:0]  dqs_out_s2, upd_done_s2, upd_tmo_s2;
  logic        so_s2;
  logic [3:0]  dqs_out_d16, upd_done_d16, upd_tmo_d16;
  logic        so_d16;
  logic [11:0] trim;

  int n_vec, n_err;
  logic [3:0] tog_mask;
  int tog_ph;

  bw_ioslave_dlx dut (
    .clk(clk), .rst_l(rst_l), .dqs_in(dqs_in), .lpf_out(lpf_out), .strobe(strobe),
    .se(se), .si(si), .dqs_out(dqs_out), .so(so), .upd_done(upd_done), .upd_tmo(upd_tmo)
`ifdef BW_IOSLAVE_DL_TRIM_EN
    , .trim(trim)
`endif
  );

  bw_ioslave_dlx #(.SHIFT(2)) dut_s2 (
    .clk(clk), .rst_l(rst_l), .dqs_in(dqs_in), .lpf_out(lpf_out), .strobe(strobe),
    .se(se), .si(si), .dqs_out(dqs_out_s2), .so(so_s2), .upd_done(upd_done_s2),
    .upd_tmo(upd_tmo_s2)
`ifdef BW_IOSLAVE_DL_TRIM_EN
    , .trim(trim)
`endif
  );

  bw_ioslave_dlx #(.DEPTH(16), .SEL_W(4)) dut_d16 (
    .clk(clk), .rst_l(rst_l), .dqs_in(dqs_in), .lpf_out(lpf_out), .strobe(strobe),
    .se(se), .si(si), .dqs_out(dqs_out_d16), .so(so_d16), .upd_done(upd_done_d16),
    .upd_tmo(upd_tmo_d16)
`ifdef BW_IOSLAVE_DL_TRIM_EN
    , .trim(trim)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tog_mask != 4'b0) begin
      tog_ph++;
      if (tog_ph == 4) begin
        tog_ph = 0;
        dqs_in = dqs_in ^ tog_mask;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n, pulses, m;
    logic [3:0] d1, t1;
    logic acc;
    int p [5];
    p = '{1, 0, 1, 1, 0};
    n_vec = 0; n_err = 0; tog_mask = 4'b0; tog_ph = 0;
    rst_l = 1'b0; dqs_in = 4'b0; lpf_out = '0; strobe = 1'b0; se = 1'b0; si = 1'b0;
    trim = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dqs_out", 32'(dqs_out), 32'h0);
    chk("rst_upd_done", 32'(upd_done), 32'h0);
    chk("rst_upd_tmo", 32'(upd_tmo), 32'h0);
    chk("rst_so", 32'(so), 32'h0);
    rst_l = 1'b1;
    steps(2);

    // Capture code 8 on quiet lines
    lpf_out = 5'd8; strobe = 1'b1;
    step();
    strobe = 1'b0;
    chk("cap_no_early_done", 32'(upd_done), 32'h0);
    step();
    chk("cap_done_all", 32'(upd_done), 32'hF);
    chk("cap_sel0", 32'(dut.sel_q[0]), 32'd8);
    chk("cap_sel3", 32'(dut.sel_q[3]), 32'd8);
    step();
    chk("cap_done_pulse_len", 32'(upd_done), 32'h0);

    // Rising edge latency sel+2
    dqs_in = 4'b0001;
    n = 0;
    while (n < 40 && dqs_out[0] !== 1'b1) begin step(); n++; end
    chk("latency_sel8", 32'(n), 32'd10);
    dqs_in = 4'b0; steps(40);

    // Timeout on a busy channel
    lpf_out = 5'd2; strobe = 1'b1; step(); strobe = 1'b0; step();
    chk("sel0_is_2", 32'(dut.sel_q[0]), 32'd2);
    tog_mask = 4'b0001; tog_ph = 0; steps(40);
    lpf_out = 5'd20; strobe = 1'b1; step(); strobe = 1'b0;
    n = 0; d1 = '0; t1 = '0;
    while (n < 200 && upd_done[0] !== 1'b1) begin
      step(); n++;
      if (n == 1) begin d1 = upd_done; t1 = upd_tmo; end
    end
    chk("tmo_cycles", 32'(n), 32'd64);
    chk("static_ch_done", 32'(d1[3:1]), 32'h7);
    chk("static_ch_tmo", 32'(t1[3:1]), 32'h0);
    chk("tmo_flag", 32'(upd_tmo), 32'h1);
    chk("tmo_sel0", 32'(dut.sel_q[0]), 32'd20);
    step();
    chk("tmo_sticky", 32'(upd_tmo), 32'h1);
    tog_mask = 4'b0; dqs_in = 4'b0; steps(120);

    // SHIFT and clamp
    lpf_out = 5'd31; strobe = 1'b1; step(); strobe = 1'b0; steps(2);
    chk("shift2_sel", 32'(dut_s2.sel_q[0]), 32'd7);
    chk("depth16_clamp", 32'(dut_d16.sel_q[0]), 32'd15);
    chk("depth32_sel31", 32'(dut.sel_q[1]), 32'd31);

    // Back-to-back strobe while channel 1 pending
    tog_mask = 4'b0010; tog_ph = 0; steps(40);
    pulses = 0;
    lpf_out = 5'd4; strobe = 1'b1; step(); strobe = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); if (upd_done[1]) pulses++; end
    lpf_out = 5'd12; strobe = 1'b1; step(); strobe = 1'b0;
    if (upd_done[1]) pulses++;
    n = 0;
    while (n < 200 && upd_done[1] !== 1'b1) begin step(); n++; end
    if (upd_done[1]) pulses++;
    for (int k = 0; k < 5; k++) begin step(); if (upd_done[1]) pulses++; end
    chk("b2b_restart_cycles", 32'(n), 32'd64);
    chk("b2b_single_pulse", 32'(pulses), 32'd1);
    chk("b2b_sel1", 32'(dut.sel_q[1]), 32'd12);
    chk("b2b_sel0", 32'(dut.sel_q[0]), 32'd12);
    tog_mask = 4'b0; dqs_in = 4'b0; steps(120);

    // Scan shift with strobe held
    se = 1'b1; strobe = 1'b1; lpf_out = 5'd3; acc = 1'b0;
    for (m = 1; m <= 41; m++) begin
      si = p[(m - 1) % 5][0];
      step();
      acc = acc | (|upd_done);
      if (m >= 21) chk("scan_so", 32'(so), 32'(p[(m - 21) % 5]));
    end
    se = 1'b0; strobe = 1'b0; si = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); acc = acc | (|upd_done); end
    chk("scan_no_done", 32'(acc), 32'h0);
    chk("scan_sel2", 32'(dut.sel_q[2]), 32'd13);

    // Reset mid-PEND
    tog_mask = 4'b0100; tog_ph = 0; steps(40);
    lpf_out = 5'd31; strobe = 1'b1; step(); strobe = 1'b0; steps(5);
    chk("pend_before_rst", 32'(upd_done[2]), 32'h0);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_dqs_out", 32'(dqs_out), 32'h0);
    chk("arst_upd_done", 32'(upd_done), 32'h0);
    chk("arst_upd_tmo", 32'(upd_tmo), 32'h0);
    chk("arst_so", 32'(so), 32'h0);
    chk("arst_sel2", 32'(dut.sel_q[2]), 32'h0);
    steps(2);
    rst_l = 1'b1; tog_mask = 4'b0; dqs_in = 4'b0; acc = 1'b0;
    for (int k = 0; k < 80; k++) begin step(); acc = acc | (|upd_done); end
    chk("rst_abandon_no_pulse", 32'(acc), 32'h0);

`ifdef BW_IOSLAVE_DL_TRIM_EN
    trim = 12'b011_101_000_000;
    lpf_out = 5'd1; strobe = 1'b1; step(); strobe = 1'b0; steps(2);
    chk("trim_neg_clamp", 32'(dut.sel_q[2]), 32'd0);
    chk("trim_pos", 32'(dut.sel_q[3]), 32'd4);
    lpf_out = 5'd30; strobe = 1'b1; step(); strobe = 1'b0; steps(2);
    chk("trim_pos_clamp", 32'(dut.sel_q[3]), 32'd31);
    chk("trim_neg", 32'(dut.sel_q[2]), 32'd27);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
